// File: rtl/mem_debug_dumper.sv
// Walks the data memory through its debug port and streams every word, LSB first, to the UART TX.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module mem_debug_dumper #(
    parameter int NB_DEPTH = 8,
    parameter int NB_DATA  = 32,
    parameter int NB_BYTE  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic [NB_DEPTH-3:0]   o_addr_debug,
    output logic                  o_debug_enb,
    input  logic [NB_DATA-1:0]    i_data_debug,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NB_WADDR = NB_DEPTH - 2;
    localparam logic [NB_WADDR-1:0] LAST_WORD = '1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] CAPT    = 3'd2;
    localparam logic [2:0] SEND    = 3'd3;
    localparam logic [2:0] WAIT_TX = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] CKSUM      = 3'd6;
    localparam logic [2:0] CKSUM_WAIT = 3'd7;
`endif

    logic [2:0]          state;
    logic [2:0]          next_state;
    logic [NB_WADDR-1:0] word_cnt;
    logic [1:0]          byte_idx;
    logic [NB_DATA-1:0]  word_reg;
    logic [NB_BYTE-1:0]  cur_byte;

    assign cur_byte = word_reg[byte_idx*NB_BYTE +: NB_BYTE];

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_start) next_state = REQ;
            REQ:     next_state = CAPT;
            CAPT:    next_state = SEND;
            SEND:    next_state = WAIT_TX;
            WAIT_TX: begin
                if (i_tx_done) begin
                    if (byte_idx != 2'd3) begin
                        next_state = SEND;
                    end else if (word_cnt != LAST_WORD) begin
                        next_state = REQ;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        next_state = CKSUM;
`else
                        next_state = DONE;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CKSUM:      next_state = CKSUM_WAIT;
            CKSUM_WAIT: if (i_tx_done) next_state = DONE;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The counter stops at the last word; the DONE path never increments it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            byte_idx <= '0;
            word_reg <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (i_start) word_cnt <= '0;
                CAPT: begin
                    word_reg <= i_data_debug;
                    byte_idx <= '0;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                        end else if (word_cnt != LAST_WORD) begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] checksum;

    // Every data byte is folded in on the cycle it is strobed out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            checksum <= '0;
        end else if (state == IDLE && i_start) begin
            checksum <= '0;
        end else if (state == SEND) begin
            checksum <= checksum ^ cur_byte;
        end
    end

    assign o_tx_data  = (state == CKSUM || state == CKSUM_WAIT) ? checksum : cur_byte;
    assign o_tx_start = (state == SEND) || (state == CKSUM);
`else
    assign o_tx_data  = cur_byte;
    assign o_tx_start = (state == SEND);
`endif

    assign o_addr_debug = word_cnt;
    assign o_debug_enb  = !(state == REQ || state == CAPT);
    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Self-checking bench for mem_debug_dumper: memory and UART models plus a byte-stream reference.
// Build with DUMP_CHECKSUM_EN defined to exercise the trailing checksum byte.
module tb_mem_debug_dumper;

    localparam int NB_DEPTH = 4;
    localparam int NB_DATA  = 32;
    localparam int NB_BYTE  = 8;
    localparam int NWORDS   = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int EXP_LEN = 17;
`else
    localparam int EXP_LEN = 16;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                uart_done = 1'b0;
    logic                extra_done = 1'b0;
    logic                model_clear = 1'b1;
    logic                tx_done;
    logic [NB_DEPTH-3:0] addr;
    logic                enb;
    logic [NB_DATA-1:0]  mem_q = '0;
    logic [NB_BYTE-1:0]  tx_data;
    logic                tx_start;
    logic                busy;
    logic                done;

    logic [31:0] mem [NWORDS];
    logic [7:0]  log_bytes [32];
    logic [7:0]  last_byte = '0;
    logic        awaiting = 1'b0;
    int          idx = 0;
    int          done_cnt = 0;
    int          ucnt = 0;
    int          errors = 0;
    int          checks = 0;

    assign tx_done = uart_done | extra_done;

    mem_debug_dumper #(.NB_DEPTH(NB_DEPTH), .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_addr_debug(addr), .o_debug_enb(enb), .i_data_debug(mem_q),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    // Data memory debug port: registers the addressed word whenever enb is low.
    always @(posedge clk) begin
        if (!enb) mem_q <= mem[addr];
    end

    // UART model: done pulses exactly three cycles after each start strobe.
    always begin
        @(posedge clk);
        #1;
        uart_done = 1'b0;
        if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) uart_done = 1'b1;
        end
        if (tx_start === 1'b1) ucnt = 3;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference byte stream: word k/4, lane k%4; the extra byte is the XOR of all data bytes.
    function automatic logic [7:0] expByte(input int k);
        logic [7:0] x;
        if (k < 4 * NWORDS) return mem[k / 4][8 * (k % 4) +: 8];
        x = 8'h00;
        for (int w = 0; w < NWORDS; w++)
            for (int b = 0; b < 4; b++)
                x = x ^ mem[w][8 * b +: 8];
        return x;
    endfunction

    // Compare process: byte stream, address walk and tx_data hold, every cycle.
    always begin
        @(posedge clk);
        #3;
        if (model_clear) begin
            idx = 0;
            done_cnt = 0;
            awaiting = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (enb === 1'b0 && idx < 4 * NWORDS)
                checkOutput("debug_addr", 32'(addr), 32'(idx / 4));
            if (tx_start === 1'b1) begin
                if (idx < EXP_LEN) begin
                    checkOutput($sformatf("byte%0d", idx), 32'(tx_data), 32'(expByte(idx)));
                end else begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_strobe: got strobe number %0d, expected only %0d", idx + 1, EXP_LEN);
                end
                if (idx < 32) log_bytes[idx] = tx_data;
                last_byte = tx_data;
                awaiting = 1'b1;
                idx++;
            end else if (awaiting) begin
                checkOutput("tx_hold", 32'(tx_data), 32'(last_byte));
                if (tx_done) awaiting = 1'b0;
            end
        end
    end

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_model();
        @(negedge clk);
        model_clear = 1'b1;
        @(negedge clk);
        model_clear = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int k;
        k = 0;
        while (done_cnt < 1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < 1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no o_done, expected one within 400 cycles", name);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_addr"}, 32'(addr), 32'h0);
        checkOutput({tag, "_enb"}, 32'(enb), 32'h1);
        checkOutput({tag, "_txdata"}, 32'(tx_data), 32'h0);
        checkOutput({tag, "_txstart"}, 32'(tx_start), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
    endtask

    initial begin
        int n;
        int k;
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;
        mem[2] = 32'hCCBBAA99;
        mem[3] = 32'h00FFEEDD;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        model_clear = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] word contents and start latency");
        applyStimulus();
        checkOutput("req_enb", 32'(enb), 32'h0);
        checkOutput("req_addr", 32'(addr), 32'h0);
        checkOutput("req_busy", 32'(busy), 32'h1);
        checkOutput("req_txstart", 32'(tx_start), 32'h0);
        @(negedge clk);
        checkOutput("capt_enb", 32'(enb), 32'h0);
        checkOutput("capt_txstart", 32'(tx_start), 32'h0);
        @(negedge clk);
        checkOutput("first_txstart", 32'(tx_start), 32'h1);
        checkOutput("first_enb", 32'(enb), 32'h1);
        wait_finish("contents");
        checkOutput("contents_count", 32'(idx), 32'(EXP_LEN));
        checkOutput("contents_done", 32'(done_cnt), 32'h1);
        checkOutput("lit_byte0", 32'(log_bytes[0]), 32'h11);
        checkOutput("lit_byte5", 32'(log_bytes[5]), 32'h66);
        checkOutput("lit_byte10", 32'(log_bytes[10]), 32'hBB);
        checkOutput("lit_byte15", 32'(log_bytes[15]), 32'h00);
`ifdef DUMP_CHECKSUM_EN
        checkOutput("lit_cksum", 32'(log_bytes[16]), 32'h00);
`endif

        $display("[TB] start pulses while busy");
        clear_model();
        applyStimulus();
        k = 0;
        while (done_cnt < 1 && k < 400) begin
            @(negedge clk);
            start = (busy && (k % 7 == 3)) ? 1'b1 : 1'b0;
            k++;
        end
        start = 1'b0;
        wait_finish("busy_start");
        checkOutput("busy_count", 32'(idx), 32'(EXP_LEN));
        checkOutput("busy_done", 32'(done_cnt), 32'h1);
        checkOutput("busy_idle", 32'(busy), 32'h0);

        $display("[TB] start coincident with done");
        clear_model();
        applyStimulus();
        k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("atdone_busy", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        checkOutput("atdone_count", 32'(idx), 32'(EXP_LEN));
        checkOutput("atdone_done", 32'(done_cnt), 32'h1);

        $display("[TB] reset mid-dump");
        clear_model();
        applyStimulus();
        n = 0;
        k = 0;
        while (n < 6 && k < 400) begin
            @(negedge clk);
            if (tx_done) n++;
            k++;
        end
        checkOutput("mid_done_seen", 32'(n), 32'd6);
        @(negedge clk);
        rst = 1'b1;
        model_clear = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear = 1'b0;
        check_reset_outputs("midreset");
        repeat (10) @(negedge clk);
        checkOutput("midreset_nodone", 32'(done_cnt), 32'h0);
        checkOutput("midreset_nostrobe", 32'(idx), 32'h0);
        applyStimulus();
        wait_finish("after_reset");
        checkOutput("after_reset_count", 32'(idx), 32'(EXP_LEN));
        checkOutput("after_reset_done", 32'(done_cnt), 32'h1);
        checkOutput("after_reset_byte0", 32'(log_bytes[0]), 32'h11);

        $display("[TB] spurious tx_done in REQ and SEND");
        clear_model();
        applyStimulus();
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        k = 0;
        while (tx_start !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        wait_finish("spurious");
        checkOutput("spurious_count", 32'(idx), 32'(EXP_LEN));
        checkOutput("spurious_done", 32'(done_cnt), 32'h1);
        checkOutput("spurious_byte1", 32'(log_bytes[1]), 32'h22);

        $display("[TB] modified word 0");
        mem[0] = 32'h00000001;
        clear_model();
        applyStimulus();
        wait_finish("word0");
        checkOutput("word0_count", 32'(idx), 32'(EXP_LEN));
        checkOutput("word0_byte0", 32'(log_bytes[0]), 32'h01);
        checkOutput("word0_byte1", 32'(log_bytes[1]), 32'h00);
        checkOutput("word0_byte4", 32'(log_bytes[4]), 32'h55);
`ifdef DUMP_CHECKSUM_EN
        checkOutput("word0_cksum", 32'(log_bytes[16]), 32'h45);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_debug_dumper.md
# mem_debug_dumper

Debug-side reader for the data memory's debug port. On a start pulse it walks every word of the data memory through the debug address/enable interface, captures each 32-bit word, and serialises it byte by byte to the UART transmitter. It sits between the data memory and the debug UART TX in the debug unit, and it is active only while the pipeline is halted.

## Interface
Parameters:
- NB_DEPTH, 8, byte-address width of the data memory; word-address width is NB_DEPTH-2.
- NB_DATA, 32, debug word width.
- NB_BYTE, 8, UART byte width.

Ports:
- i_clk  input  1  clock; all logic on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle request to start a dump.
- o_addr_debug  output  NB_DEPTH-2  word address to the data memory debug port.
- o_debug_enb  output  1  memory mode select. 1 = memory serves the pipeline. 0 = memory registers the word at o_addr_debug.
- i_data_debug  input  NB_DATA  registered debug word from the memory, valid one cycle after the request.
- o_tx_data  output  NB_BYTE  byte to the UART TX.
- o_tx_start  output  1  one-cycle strobe to the UART TX.
- i_tx_done  input  1  one-cycle pulse from the UART TX when the current byte has been sent.
- o_busy  output  1  high from the cycle after start acceptance until DONE is left.
- o_done  output  1  one-cycle pulse when the dump completes.

## Operation
- States:
  - IDLE
  - REQ: drive o_addr_debug = word counter, o_debug_enb = 0.
  - CAPT: o_debug_enb = 0; latch i_data_debug into the word register at the end of the cycle; byte index = 0.
  - SEND: o_tx_data = word register byte[byte index]; o_tx_start = 1 for exactly one cycle.
  - WAIT_TX: hold o_tx_data; wait for i_tx_done.
  - CKSUM: only when the checksum feature is compiled in.
  - DONE
- Transitions:
  - IDLE → REQ on i_start. Word counter = 0.
  - REQ → CAPT unconditionally.
  - CAPT → SEND unconditionally.
  - SEND → WAIT_TX unconditionally.
  - WAIT_TX on i_tx_done:
    - byte index < 3: increment byte index, go to SEND.
    - byte index = 3 and word counter < 2^(NB_DEPTH-2)-1: increment word counter, go to REQ.
    - byte index = 3 and word counter = all ones: go to DONE, or to CKSUM when it is compiled in.
  - DONE → IDLE, pulsing o_done.
- Byte order: least-significant byte first (byte lane 0 first), so each word goes out as bits [7:0], [15:8], [23:16], [31:24].
- Word counter: width NB_DEPTH-2, unsigned. The last word is all ones; the counter never wraps past it into a second pass.
- o_debug_enb is 0 only in REQ and CAPT; it is 1 in every other state.
- Total bytes sent: 4·2^(NB_DEPTH-2).

## Timing
- Reset values:
  - o_addr_debug = 0, o_debug_enb = 1, o_tx_data = 0, o_tx_start = 0, o_busy = 0, o_done = 0.
  - State = IDLE; counters and word register = 0.
- Reset mid-dump: return to IDLE on the next edge. No o_done pulse, o_debug_enb = 1 immediately, no further o_tx_start.
- i_start sampled in cycle t:
  - REQ in t+1.
  - CAPT in t+2, with memory data valid.
  - First o_tx_start in t+3.
- Word to word: i_tx_done for byte 3 in cycle u gives REQ in u+1 and the next o_tx_start in u+3.
- Byte to byte within a word: i_tx_done in cycle u gives o_tx_start in u+1.
- i_start is ignored outside IDLE. i_start in the same cycle as the o_done pulse (DONE) is also ignored.
- i_tx_done is ignored in every state except WAIT_TX, including SEND.
- o_tx_data is stable from SEND until the WAIT_TX cycle that sees i_tx_done.

## Configuration
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of all transmitted data bytes is kept; it is cleared on start acceptance.
  - After the last data byte's i_tx_done: go to CKSUM, which drives the checksum on o_tx_data with an o_tx_start pulse, then waits for i_tx_done and goes to DONE.
  - Total bytes = 4·2^(NB_DEPTH-2)+1.
- Undefined: no checksum register and no CKSUM state; WAIT_TX goes directly to DONE.

## Test plan
- Word contents: NB_DEPTH=4 (4 words), memory words 0x44332211, 0x88776655, 0xCCBBAA99, 0x00FFEEDD. UART model pulses i_tx_done 3 cycles after o_tx_start. Start → exactly 16 tx_start strobes, bytes 11 22 33 44 55 66 77 88 99 AA BB CC DD EE FF 00, one o_done.
- Latency: start at cycle 10 → REQ with o_debug_enb=0 and addr 0 at cycle 11, first o_tx_start at cycle 13.
- Start while busy: i_start pulses during WAIT_TX → still 16 bytes, one o_done, no restart. i_start coincident with o_done → no new dump.
- Reset mid-dump: i_rst for one cycle after the 6th i_tx_done → all outputs at reset values, o_debug_enb=1, no o_done. A following start → a full 16-byte dump from address 0.
- Spurious done: i_tx_done asserted in the SEND cycle and in REQ → ignored; byte sequence unchanged.
- Checksum: with DUMP_CHECKSUM_EN defined, same contents as the word-contents scenario → 17th byte equals the XOR of the 16 data bytes (0x00). Repeat with word 0 = 0x00000001 → final byte 0x01 XOR the remaining bytes.
